module_keypad: RTL and testbench
================================

# module_keypad

4x4 matrix keypad scanner for the 27 MHz board design. It is the input-side counterpart of the multiplexed 7-segment display driver. The display scans anodes to write digits; this block scans keypad columns to read keys. It debounces the scanned matrix and delivers a one-cycle `key_valid_po` strobe with a 4-bit key code, which the accumulator logic consumes in place of the dipswitch/`suma_btn` pair.

## Interface
Parameters:
- `SCAN_DIV`, 27000: clock cycles per column slot (1 ms at 27 MHz). Minimum 4.
- `DEBOUNCE_SCANS`, 8: consecutive identical full scans required to accept a press or a release. Range 1-255.
- `REPEAT_SCANS`, 100: full scans between auto-repeat strobes. Used only with `KEYPAD_REPEAT_EN`.

Ports:
- `clk_pi` in 1: system clock, 27 MHz.
- `rst_pi` in 1: asynchronous reset, **active-low**.
- `row_pi` in 4: keypad rows. Asynchronous, pulled up, low = key closed on the driven column.
- `col_po` out 4: column drive. Exactly one bit is low at any time; the others are high.
- `key_po` out 4: last accepted key code, `{row_idx[1:0], col_idx[1:0]}`.
- `key_valid_po` out 1: one-cycle strobe; `key_po` is valid and updated in the same cycle.
- `key_held_po` out 1: high while the accepted key is considered pressed.

## Operation
- **Row input:** `row_pi` passes through a 2-FF synchronizer before any use.
- **Column scan:**
  - Slot counter counts 0..`SCAN_DIV`-1.
  - Column index advances 0→1→2→3→0 at slot wrap.
  - `col_po` = `~(4'b0001 << col_idx)`.
- **Sampling:** the synchronized rows are sampled into a 16-bit snapshot in the last cycle of each slot (cycle `SCAN_DIV`-1). The preceding cycles allow settling.
- **Scan complete:** a scan completes at the sample cycle of column 3. The snapshot then classifies as one of:
  - NONE: zero keys closed.
  - SINGLE(code): exactly one key closed.
  - MULTI: two or more keys closed. MULTI is never accepted as a key.
- **Stability counter (8 bits):**
  - At each scan complete, if the classification equals the previous scan's classification, the counter increments, saturating at 255.
  - Otherwise the counter loads 1.
- **FSM (evaluated only at scan complete):**
  - IDLE: if SINGLE and count == `DEBOUNCE_SCANS`, go to PRESSED. In the same evaluation, load `key_po` = code, pulse `key_valid_po`, and set `key_held_po` = 1.
  - PRESSED:
    - If NONE and count == `DEBOUNCE_SCANS`, go to IDLE and clear `key_held_po`. No strobe.
    - SINGLE with a different code, or MULTI, keeps PRESSED with no new strobe. A release is required before the next key.
- **Held key:** a held key produces exactly one strobe. `key_po` keeps its last accepted value after release.

## Timing
- **Reset values:** `col_po` = 4'b1110, `key_po` = 0, `key_valid_po` = 0, `key_held_po` = 0. All counters = 0; FSM = IDLE; previous classification = NONE.
- **Input to sample:** 2 cycles synchronizer latency.
- **Scan period:** 4×`SCAN_DIV` cycles.
- **Strobe timing:**
  - `key_valid_po` and `key_held_po` rise in the cycle immediately after the scan-complete sample cycle of the accepting scan.
  - `key_valid_po` is high for exactly 1 cycle.
  - `key_held_po` falls in the cycle after the accepting release scan.
- **Reset mid-operation:** outputs return to reset values asynchronously. After deassertion, a held key needs a full `DEBOUNCE_SCANS` again and produces a fresh strobe.
- **Bounce:** any classification change resets the count to 1, so bounce shorter than `DEBOUNCE_SCANS` scans never produces a strobe.

## Configuration
- `KEYPAD_REPEAT_EN` defined: auto-repeat is enabled.
  - A repeat counter, cleared on entering PRESSED, counts scan completes while PRESSED with SINGLE(same code).
  - On reaching `REPEAT_SCANS`, the block pulses `key_valid_po` (same `key_po`) and clears the counter.
  - Any other classification clears the counter.
- `KEYPAD_REPEAT_EN` not defined: no repeat logic; one strobe per press.

## Test plan
Use `SCAN_DIV`=4, `DEBOUNCE_SCANS`=3, `REPEAT_SCANS`=5 (scan period = 16 cycles). The bench models the matrix as `row_pi[r]` = 0 when key (r,c) is closed and `col_po[c]`=0.
- **Reset:** assert `rst_pi`=0 mid-scan → `col_po`=1110, `key_po`=0, `key_valid_po`=0 and `key_held_po`=0 immediately; column 0 driven after release.
- **Clean press:** close key (2,1) and hold → exactly one strobe with `key_po`=4'b1001, within ≤4 scans (≤64 cycles + 2); `key_held_po`=1 thereafter.
- **Bounce:** toggle key (0,3) every 5 cycles for 60 cycles, then hold closed → exactly one strobe (`key_po`=4'b0011), no earlier strobe.
- **Ghost/multi:** close keys (1,0) and (3,2) together for 10 scans → no strobe, `key_held_po` stays 0. Release (3,2) → strobe with `key_po`=4'b0100.
- **Release and change:** while (2,1) is PRESSED, move to (3,3) without a NONE gap → no strobe. Open all keys → `key_held_po` falls after 3 NONE scans. Then press (3,3) → strobe with `key_po`=4'b1111.
- **With `KEYPAD_REPEAT_EN`:** hold (1,1) for 20 scans → initial strobe plus one strobe every 5 scans, all with `key_po`=4'b0101. Without the macro → exactly one strobe.

Source files
------------

// File: rtl/module_keypad.sv
// 4x4 matrix keypad scanner: column scan, full-scan debounce, one-cycle key strobe.
// Optional auto-repeat of a held key when KEYPAD_REPEAT_EN is defined.
module module_keypad #(
   parameter int unsigned SCAN_DIV       = 27000,
   parameter int unsigned DEBOUNCE_SCANS = 8,
   parameter int unsigned REPEAT_SCANS   = 100
) (
   input  logic       clk_pi,
   input  logic       rst_pi,
   input  logic [3:0] row_pi,
   output logic [3:0] col_po,
   output logic [3:0] key_po,
   output logic       key_valid_po,
   output logic       key_held_po
);

   if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 255 || REPEAT_SCANS < 1) begin : g_param_check
      $error("module_keypad: parameter out of range");
   end

   localparam int unsigned SW = $clog2(SCAN_DIV);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

   localparam logic [1:0] CLS_NONE   = 2'd0;
   localparam logic [1:0] CLS_SINGLE = 2'd1;
   localparam logic [1:0] CLS_MULTI  = 2'd2;

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_PRESSED = 1'b1;

   logic [3:0]    row_meta, row_sync;
   logic [SW-1:0] slot_cnt;
   logic [1:0]    col_idx;
   logic [15:0]   snap, snap_next;
   logic [1:0]    prev_cls, cls, n_closed;
   logic [3:0]    prev_code, hit_code;
   logic [7:0]    stab_cnt, cnt_next;
   logic [0:0]    state;
   logic [3:0]    key_q;
   logic          valid_q, held_q;
   logic          sample, scan_done, same_cls, accept, release_key, rep_fire;

   assign sample    = (slot_cnt == SLOT_LAST);
   assign scan_done = sample && (col_idx == 2'd3);

   // Snapshot is column-major: bit col*4+row set means that key is closed.
   always_comb begin
      snap_next = snap;
      if (sample) snap_next[{col_idx, 2'b00} +: 4] = ~row_sync;
   end

   always_comb begin
      n_closed = 2'd0;
      hit_code = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (snap_next[i]) begin
            if (n_closed == 2'd0) hit_code = {2'(i % 4), 2'(i / 4)};
            if (n_closed != 2'd2) n_closed = n_closed + 2'd1;
         end
      end
      case (n_closed)
         2'd0:    cls = CLS_NONE;
         2'd1:    cls = CLS_SINGLE;
         default: cls = CLS_MULTI;
      endcase
   end

   assign same_cls = (cls == prev_cls) && ((cls != CLS_SINGLE) || (hit_code == prev_code));

   always_comb begin
      if (!same_cls)              cnt_next = 8'd1;
      else if (stab_cnt == 8'hFF) cnt_next = 8'hFF;
      else                        cnt_next = stab_cnt + 8'd1;
   end

   assign accept      = scan_done && (state == ST_IDLE) && (cls == CLS_SINGLE)
                        && (cnt_next == 8'(DEBOUNCE_SCANS));
   assign release_key = scan_done && (state == ST_PRESSED) && (cls == CLS_NONE)
                        && (cnt_next == 8'(DEBOUNCE_SCANS));

`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned RW = $clog2(REPEAT_SCANS + 1);
   logic [RW-1:0] rep_cnt, rep_inc;
   logic          rep_hold;

   assign rep_inc  = rep_cnt + RW'(1);
   assign rep_hold = (state == ST_PRESSED) && (cls == CLS_SINGLE) && (hit_code == key_q);
   assign rep_fire = scan_done && rep_hold && (rep_inc == RW'(REPEAT_SCANS));

   // Entering PRESSED happens from IDLE, where rep_hold is low, so the counter starts at zero.
   always_ff @(posedge clk_pi or negedge rst_pi) begin
      if (!rst_pi) begin
         rep_cnt <= '0;
      end else if (scan_done) begin
         rep_cnt <= (rep_hold && !rep_fire) ? rep_inc : '0;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   always_ff @(posedge clk_pi or negedge rst_pi) begin
      if (!rst_pi) begin
         row_meta  <= 4'hF;
         row_sync  <= 4'hF;
         slot_cnt  <= '0;
         col_idx   <= 2'd0;
         snap      <= 16'd0;
         prev_cls  <= CLS_NONE;
         prev_code <= 4'd0;
         stab_cnt  <= 8'd0;
         state     <= ST_IDLE;
         key_q     <= 4'd0;
         valid_q   <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         row_meta <= row_pi;
         row_sync <= row_meta;
         if (sample) begin
            slot_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
         end else begin
            slot_cnt <= slot_cnt + SW'(1);
         end
         snap    <= snap_next;
         valid_q <= accept | rep_fire;
         if (scan_done) begin
            prev_cls  <= cls;
            prev_code <= hit_code;
            stab_cnt  <= cnt_next;
            if (accept) begin
               state  <= ST_PRESSED;
               key_q  <= hit_code;
               held_q <= 1'b1;
            end else if (release_key) begin
               state  <= ST_IDLE;
               held_q <= 1'b0;
            end
         end
      end
   end

   assign col_po       = ~(4'b0001 << col_idx);
   assign key_po       = key_q;
   assign key_valid_po = valid_q;
   assign key_held_po  = held_q;

endmodule

// File: tb/tb_module_keypad.sv
// Self-checking bench for module_keypad: directed scenarios plus random key patterns,
// every cycle compared against a scan-level behavioural model (honours KEYPAD_REPEAT_EN).
module tb_module_keypad;

   localparam int unsigned SD = 4;
   localparam int unsigned DB = 3;
   localparam int unsigned RS = 5;
   localparam int unsigned SCAN = 4 * SD;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  row, col, key;
   logic        valid, held;
   logic [15:0] keys = 16'd0;  // bit r*4+c set = key (r,c) closed

   int errors = 0;
   int checks = 0;
   int strobes = 0;
   logic [3:0] last_key = 4'd0;

   // Behavioural model state
   int m_slot, m_col, m_prev, m_cnt, m_rep;
   bit m_pressed, m_valid, m_held;
   logic [3:0]  m_key;
   logic [15:0] m_h1, m_h2, m_snap;

   module_keypad #(
      .SCAN_DIV       (SD),
      .DEBOUNCE_SCANS (DB),
      .REPEAT_SCANS   (RS)
   ) dut (
      .clk_pi       (clk),
      .rst_pi       (rst_n),
      .row_pi       (row),
      .col_po       (col),
      .key_po       (key),
      .key_valid_po (valid),
      .key_held_po  (held)
   );

   always #5 clk = ~clk;

   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         if (|(keys[r*4 +: 4] & ~col)) row[r] = 1'b0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_slot = 0; m_col = 0; m_prev = 16; m_cnt = 0; m_rep = 0;
      m_pressed = 0; m_valid = 0; m_held = 0; m_key = 4'd0;
      m_h1 = 16'd0; m_h2 = 16'd0; m_snap = 16'd0;
   endtask

   // One clock edge: the sample uses the key state from two edges back (synchronizer).
   task automatic model_edge();
      int c, n;
      m_valid = 0;
      if (m_slot == SD - 1) begin
         for (int r = 0; r < 4; r++) m_snap[r*4 + m_col] = m_h2[r*4 + m_col];
         if (m_col == 3) begin
            n = $countones(m_snap);
            c = (n == 0) ? 16 : 17;
            if (n == 1)
               for (int i = 0; i < 16; i++) if (m_snap[i]) c = i;
            m_cnt  = (c == m_prev) ? ((m_cnt < 255) ? m_cnt + 1 : 255) : 1;
            m_prev = c;
            if (!m_pressed) begin
               if (c < 16 && m_cnt == DB) begin
                  m_pressed = 1; m_key = 4'(c); m_valid = 1; m_held = 1; m_rep = 0;
               end
            end else begin
`ifdef KEYPAD_REPEAT_EN
               if (c == int'(m_key)) begin
                  m_rep++;
                  if (m_rep == RS) begin m_valid = 1; m_rep = 0; end
               end else m_rep = 0;
`endif
               if (c == 16 && m_cnt == DB) begin m_pressed = 0; m_held = 0; end
            end
         end
      end
      m_h2 = m_h1;
      m_h1 = keys;
      if (m_slot == SD - 1) begin m_slot = 0; m_col = (m_col + 1) % 4; end
      else m_slot++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("col_po", col, 4'hF ^ (4'd1 << m_col));
      chk("key_valid_po", valid, m_valid);
      chk("key_held_po", held, m_held);
      chk("key_po", key, m_key);
      if (valid === 1'b1) begin strobes++; last_key = key; end
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_strobe(input string tag, input int limit);
      int n = 0;
      int s = strobes;
      while (strobes == s && n < limit) begin tick(); n++; end
      chk(tag, strobes > s, 1);
   endtask

   initial begin
      int s, n, bad;
      model_reset();
      #1 rst_n = 1'b0;
      #3;
      chk("reset col_po", col, 4'b1110);
      chk("reset key_po", key, 4'd0);
      chk("reset key_valid_po", valid, 1'b0);
      chk("reset key_held_po", held, 1'b0);
      @(negedge clk) rst_n = 1'b1;

      // Clean press of (2,1)
      keys = 16'd1 << 9;
      s = strobes;
      wait_strobe("clean press strobe within 66 cycles", 66);
      run(2 * SCAN);
      chk("clean press strobe count", strobes - s, 1);
      chk("clean press key", last_key, 4'b1001);
      chk("clean press held", held, 1'b1);
      keys = 16'd0;
      run(5 * SCAN);
      chk("release held", held, 1'b0);

      // Bounce on (0,3), then hold
      s = strobes;
      for (int i = 0; i < 12; i++) begin
         keys = keys ^ (16'd1 << 3);
         run(5);
      end
      chk("bounce no early strobe", strobes - s, 0);
      keys = 16'd1 << 3;
      wait_strobe("bounce strobe after hold", 5 * SCAN);
      chk("bounce strobe count", strobes - s, 1);
      chk("bounce key", last_key, 4'b0011);
      keys = 16'd0;
      run(5 * SCAN);

      // Ghost/multi: (1,0) + (3,2)
      s = strobes;
      keys = (16'd1 << 4) | (16'd1 << 14);
      run(10 * SCAN);
      chk("multi no strobe", strobes - s, 0);
      chk("multi held low", held, 1'b0);
      keys = 16'd1 << 4;
      wait_strobe("multi release strobe", 5 * SCAN);
      chk("multi release key", last_key, 4'b0100);
      keys = 16'd0;
      run(5 * SCAN);

      // Change key without release, then release and press the new one
      keys = 16'd1 << 9;
      wait_strobe("change first press", 5 * SCAN);
      s = strobes;
      keys = 16'd1 << 15;
      run(6 * SCAN);
      chk("change no strobe", strobes - s, 0);
      chk("change still held", held, 1'b1);
      keys = 16'd0;
      run(2 * SCAN);
      chk("held before third NONE scan", held, 1'b1);
      n = 0;
      while (held === 1'b1 && n < 3 * SCAN) begin tick(); n++; end
      chk("held falls after release", held, 1'b0);
      keys = 16'd1 << 15;
      wait_strobe("press (3,3)", 5 * SCAN);
      chk("press (3,3) key", last_key, 4'b1111);
      keys = 16'd0;
      run(5 * SCAN);

      // Hold (1,1) for 20 scans
      s = strobes;
      bad = 0;
      keys = 16'd1 << 5;
      for (int i = 0; i < 20 * SCAN; i++) begin
         tick();
         if (valid === 1'b1 && key !== 4'b0101) bad++;
      end
`ifdef KEYPAD_REPEAT_EN
      chk("hold 20 scans strobe count", strobes - s, 4);
`else
      chk("hold 20 scans strobe count", strobes - s, 1);
`endif
      chk("hold strobes key 0101", bad, 0);
      keys = 16'd0;
      run(5 * SCAN);

      // Random key patterns, checked cycle by cycle against the model
      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0:       keys = 16'd0;
            3:       keys = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
            default: keys = 16'd1 << $urandom_range(0, 15);
         endcase
         run($urandom_range(1, 7) * SCAN + $urandom_range(0, 15));
      end

      // Reset mid-operation with a key held
      keys = 16'd1 << 6;
      run(6 * SCAN + 5);
      #2 rst_n = 1'b0;
      #1;
      chk("mid reset col_po", col, 4'b1110);
      chk("mid reset key_po", key, 4'd0);
      chk("mid reset key_valid_po", valid, 1'b0);
      chk("mid reset key_held_po", held, 1'b0);
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      s = strobes;
      wait_strobe("fresh strobe after reset", 5 * SCAN);
      chk("fresh strobe key", last_key, 4'b0110);
      chk("fresh strobe held", held, 1'b1);
      keys = 16'd0;
      run(5 * SCAN);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
